// File: rtl/access_lockout_ctrl.sv
// Attempt-policy controller placed between the password comparator and the stepper drive.
// Turns comparator result levels into single attempt events, grants a timed unlock window
// on success, counts consecutive failures and enforces a timed lockout with a sticky alarm.
module access_lockout_ctrl #(
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned OPEN_CYCLES = 500,
    parameter int unsigned LOCK_CYCLES = 1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       match,
    input  logic       not_match,
    input  logic       alarm_clr,
    output logic       unlock,
    output logic       locked,
    output logic       alarm,
    output logic [2:0] fail_cnt
);

    // Elaboration-time guards on the parameter ranges.
    if (MAX_FAIL < 1 || MAX_FAIL > 7) begin : g_bad_max_fail
        $error("MAX_FAIL must be in 1..7");
    end
    if (OPEN_CYCLES < 1 || 64'(OPEN_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_open
        $error("OPEN_CYCLES must be >= 1 and fit in CNT_W bits");
    end
    if (LOCK_CYCLES < 1 || 64'(LOCK_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_lock
        $error("LOCK_CYCLES must be >= 1 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] OpenLast = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]       MaxFail  = 4'(MAX_FAIL);

    typedef enum logic [1:0] {
        StIdle,
        StOpen,
        StLockout
    } state_e;

    state_e           state_q;
    logic             match_q;
    logic             nm_q;
    logic [CNT_W-1:0] timer_q;
    logic [2:0]       fail_q;
    logic             alarm_q;

    logic             success_ev;
    logic             fail_ev;
    logic [3:0]       fail_inc;
    logic             fail_limit;

    // Rising-edge event detection and failure-limit decode.
    always_comb begin
        success_ev = match & ~match_q;
        fail_ev    = not_match & ~nm_q;
        // One bit wider than the count so the +1 can never wrap.
        fail_inc   = {1'b0, fail_q} + 4'd1;
        fail_limit = (fail_inc >= MaxFail);
    end

    // Previous input levels; reset to 1 so a level held through reset is not an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_q <= 1'b1;
            nm_q    <= 1'b1;
        end else begin
            match_q <= match;
            nm_q    <= not_match;
        end
    end

    // Policy FSM with shared window/lockout timer, failure count and sticky alarm.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            fail_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            // Clear request is honoured outside lockout; a lockout entry below overrides it.
            if (alarm_clr && (state_q != StLockout)) begin
                alarm_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    // A fail takes priority over a simultaneous success.
                    if (fail_ev) begin
                        if (fail_limit) begin
                            fail_q  <= MaxFail[2:0];
                            timer_q <= '0;
                            alarm_q <= 1'b1;
                            state_q <= StLockout;
                        end else begin
                            fail_q <= fail_inc[2:0];
                        end
                    end else if (success_ev) begin
                        fail_q  <= '0;
                        timer_q <= '0;
                        state_q <= StOpen;
                    end
                end

                StOpen: begin
                    // Events are dropped for the whole window, expiry cycle included.
                    if (timer_q == OpenLast) begin
                        timer_q <= '0;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                StLockout: begin
                    alarm_q <= 1'b1;
                    if (timer_q == LockLast) begin
                        timer_q <= '0;
                        fail_q  <= '0;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                default: begin
                    timer_q <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Window outputs decode straight from the state register so they never overlap.
    always_comb begin
        unlock   = (state_q == StOpen);
        locked   = (state_q == StLockout);
        alarm    = alarm_q;
        fail_cnt = fail_q;
    end

endmodule

// File: tb/tb_access_lockout_ctrl.sv
// Self-checking bench for access_lockout_ctrl: directed scenarios, a cycle-level
// behavioural model compared every clock, and literal expectations at key points.
module tb_access_lockout_ctrl;

    localparam int unsigned MF = 3;
    localparam int unsigned OC = 4;
    localparam int unsigned LC = 8;
    localparam int unsigned CW = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       match = 1'b0;
    logic       not_match = 1'b0;
    logic       alarm_clr = 1'b0;
    logic       unlock;
    logic       locked;
    logic       alarm;
    logic [2:0] fail_cnt;

    int vectors = 0;
    int miscompares = 0;

    access_lockout_ctrl #(
        .MAX_FAIL   (MF),
        .OPEN_CYCLES(OC),
        .LOCK_CYCLES(LC),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .match    (match),
        .not_match(not_match),
        .alarm_clr(alarm_clr),
        .unlock   (unlock),
        .locked   (locked),
        .alarm    (alarm),
        .fail_cnt (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining window/lockout cycles, failure tally, alarm flag.
    int m_open_left = 0;
    int m_lock_left = 0;
    int m_fails = 0;
    int m_alarm = 0;
    int m_pm = 1;
    int m_pn = 1;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_open_left = 0;
                m_lock_left = 0;
                m_fails     = 0;
                m_alarm     = 0;
                m_pm        = 1;
                m_pn        = 1;
            end else begin
                int  s_ev;
                int  f_ev;
                int  was_lock;
                s_ev     = (match == 1'b1 && m_pm == 0) ? 1 : 0;
                f_ev     = (not_match == 1'b1 && m_pn == 0) ? 1 : 0;
                m_pm     = match ? 1 : 0;
                m_pn     = not_match ? 1 : 0;
                was_lock = (m_lock_left > 0) ? 1 : 0;
                if (alarm_clr && !was_lock) m_alarm = 0;
                if (m_open_left > 0) begin
                    m_open_left--;
                end else if (m_lock_left > 0) begin
                    m_lock_left--;
                    if (m_lock_left == 0) m_fails = 0;
                end else if (f_ev != 0) begin
                    if (m_fails + 1 >= MF) begin
                        m_fails     = MF;
                        m_lock_left = LC;
                        m_alarm     = 1;
                    end else begin
                        m_fails++;
                    end
                end else if (s_ev != 0) begin
                    m_fails     = 0;
                    m_open_left = OC;
                end
            end
        end
    end

    // Compare DUT against the model shortly after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("model_unlock", int'(unlock), (m_open_left > 0) ? 1 : 0);
            check("model_locked", int'(locked), (m_lock_left > 0) ? 1 : 0);
            check("model_alarm", int'(alarm), m_alarm);
            check("model_fail_cnt", int'(fail_cnt), m_fails);
        end
    end

    task automatic pulse_match();
        @(negedge clk);
        match = 1'b1;
        @(negedge clk);
        match = 1'b0;
    endtask

    task automatic pulse_nm();
        @(negedge clk);
        not_match = 1'b1;
        @(negedge clk);
        not_match = 1'b0;
    endtask

    // Count cycles with unlock high over a bounded span starting at the current negedge.
    task automatic count_unlock(input int span, output int cnt);
        cnt = 0;
        for (int i = 0; i < span; i++) begin
            if (unlock) cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt;

        repeat (2) @(negedge clk);
        check("reset_unlock", int'(unlock), 0);
        check("reset_locked", int'(locked), 0);
        check("reset_alarm", int'(alarm), 0);
        check("reset_fail_cnt", int'(fail_cnt), 0);
        reset = 1'b0;

        // Scenario 1: single success gives a 4-cycle window.
        pulse_match();
        check("s1_unlock_first", int'(unlock), 1);
        count_unlock(10, cnt);
        check("s1_unlock_len", cnt, 4);
        check("s1_fail_cnt", int'(fail_cnt), 0);

        // Scenario 2/3: three failures cause lockout; clear ignored in lockout.
        pulse_nm();
        check("s2_fail1", int'(fail_cnt), 1);
        pulse_nm();
        check("s2_fail2", int'(fail_cnt), 2);
        check("s2_not_locked_yet", int'(locked), 0);
        pulse_nm();
        check("s2_fail3", int'(fail_cnt), 3);
        check("s2_locked_rise", int'(locked), 1);
        check("s2_alarm_rise", int'(alarm), 1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            alarm_clr = (i == 2) ? 1'b1 : 1'b0;
            if (locked) cnt++;
            @(negedge clk);
        end
        alarm_clr = 1'b0;
        check("s2_locked_len", cnt, 8);
        check("s2_fail_cleared", int'(fail_cnt), 0);
        check("s3_alarm_sticky", int'(alarm), 1);
        alarm_clr = 1'b1;
        @(negedge clk);
        alarm_clr = 1'b0;
        check("s3_alarm_cleared", int'(alarm), 0);

        // Scenario 4: success clears failures; events inside the window are dropped.
        pulse_nm();
        pulse_nm();
        check("s4_fail2", int'(fail_cnt), 2);
        pulse_match();
        check("s4_fail_clr", int'(fail_cnt), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            not_match = (i == 1) ? 1'b1 : 1'b0;
            match     = (i == 2) ? 1'b1 : 1'b0;
            if (unlock) cnt++;
            @(negedge clk);
        end
        match     = 1'b0;
        not_match = 1'b0;
        check("s4_unlock_len", cnt, 4);
        check("s4_fail_unchanged", int'(fail_cnt), 0);
        check("s4_no_lock", int'(locked), 0);

        // Scenario 5a: simultaneous edges count as a fail.
        @(negedge clk);
        match     = 1'b1;
        not_match = 1'b1;
        @(negedge clk);
        match     = 1'b0;
        not_match = 1'b0;
        check("s5_simul_fail", int'(fail_cnt), 1);
        check("s5_simul_no_unlock", int'(unlock), 0);

        // Scenario 5b: match held across reset release is not an event.
        match = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("s5_held_no_unlock", int'(unlock), 0);
        match = 1'b0;
        @(negedge clk);
        match = 1'b1;
        @(negedge clk);
        check("s5_rearm_unlock", int'(unlock), 1);
        match = 1'b0;
        repeat (6) @(negedge clk);

        // Scenario 6: reset mid-lockout clears everything at once.
        pulse_nm();
        pulse_nm();
        pulse_nm();
        check("s6_locked", int'(locked), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("s6_async_locked", int'(locked), 0);
        check("s6_async_alarm", int'(alarm), 0);
        check("s6_async_fail", int'(fail_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        pulse_match();
        count_unlock(10, cnt);
        check("s6_unlock_len", cnt, 4);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
